// File: rtl/cond_wb_unit_pkg.sv
// cond_wb_unit_pkg: condition codes, flag bit indices and writeback state shared by cond_wb_unit and its helpers
package cond_wb_unit_pkg;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {IDLE, WB_SINGLE, WB_LO, WB_HI} wb_state_e;
endpackage

// File: rtl/cond_wb_unit_cond_check.sv
// cond_check: combinational ARM condition evaluation of cond against {N,Z,C,V}; NV evaluates false
// Ports: cond (condition field), flags ({N,Z,C,V}), pass (condition holds)
module cond_check
  import cond_wb_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_wb_unit.sv
// cond_wb_unit: NZCV flag register, predication of PC/register/memory writes, and register-file writeback sequencing
// Inputs: Cond/ALUFlags/FlagW/CondLatch (flags and condition), PCS/RegW/MemW/NoWrite (write intents),
//   Result1/Result2/ResultLatch (ALU results), LongMul/WBStart/Rd/RdLo (writeback control).
// Outputs: Flags, CondEx, PCWrite, MemWrite, RegWrite/WA3/WD3 (register write port), ALUOut1/ALUOut2, WBBusy, WBDone.
// Macro COND_WB_LONGMUL_EN: builds the two-beat long-multiply writeback (RdLo then Rd); otherwise every writeback is one beat.
module cond_wb_unit
  import cond_wb_unit_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    Cond,
  input  logic [3:0]    ALUFlags,
  input  logic [1:0]    FlagW,
  input  logic          CondLatch,
  input  logic          PCS,
  input  logic          RegW,
  input  logic          MemW,
  input  logic          NoWrite,
  input  logic [DW-1:0] Result1,
  input  logic [DW-1:0] Result2,
  input  logic          ResultLatch,
  input  logic          LongMul,
  input  logic          WBStart,
  input  logic [AW-1:0] Rd,
  input  logic [AW-1:0] RdLo,
  output logic [3:0]    Flags,
  output logic          CondEx,
  output logic          PCWrite,
  output logic          MemWrite,
  output logic          RegWrite,
  output logic [AW-1:0] WA3,
  output logic [DW-1:0] WD3,
  output logic [DW-1:0] ALUOut1,
  output logic [DW-1:0] ALUOut2,
  output logic          WBBusy,
  output logic          WBDone
);
  logic [3:0] flags_q, flags_d;
  logic cond_ex_q, cond_ex_d;
  logic [DW-1:0] alu_out1_q, alu_out1_d, alu_out2_q, alu_out2_d;
  logic [AW-1:0] rd_q, rd_d, lo_addr;
  wb_state_e state_q, state_d;
  logic pass, idle, wb_lo;
  cond_check u_cond_check (.cond(Cond), .flags(flags_q), .pass(pass));
  assign idle = state_q == IDLE;
`ifdef COND_WB_LONGMUL_EN
  logic [AW-1:0] rd_lo_q, rd_lo_d;
  assign rd_lo_d = (WBStart && idle) ? RdLo : rd_lo_q;
  assign wb_lo = state_q == WB_LO;
  assign lo_addr = rd_lo_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rd_lo_q <= '0;
    else rd_lo_q <= rd_lo_d;
  always_comb state_d = idle ? (WBStart ? (LongMul ? WB_LO : WB_SINGLE) : IDLE) : (wb_lo ? WB_HI : IDLE);
`else
  logic unused_longmul;
  assign unused_longmul = ^{LongMul, RdLo};
  assign wb_lo = 1'b0;
  assign lo_addr = rd_q;
  always_comb state_d = (idle && WBStart) ? WB_SINGLE : IDLE;
`endif
  // Flag updates are qualified by the already-registered CondEx, not this cycle's evaluation.
  always_comb begin
    flags_d = {FlagW[1] && cond_ex_q ? ALUFlags[FLAG_N:FLAG_Z] : flags_q[FLAG_N:FLAG_Z],
               FlagW[0] && cond_ex_q ? ALUFlags[FLAG_C:FLAG_V] : flags_q[FLAG_C:FLAG_V]};
    cond_ex_d = CondLatch ? pass : cond_ex_q;
    alu_out1_d = (ResultLatch && idle) ? Result1 : alu_out1_q;
    alu_out2_d = (ResultLatch && idle) ? Result2 : alu_out2_q;
    rd_d = (WBStart && idle) ? Rd : rd_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      flags_q <= '0;
      cond_ex_q <= 1'b0;
      alu_out1_q <= '0;
      alu_out2_q <= '0;
      rd_q <= '0;
      state_q <= IDLE;
    end else begin
      flags_q <= flags_d;
      cond_ex_q <= cond_ex_d;
      alu_out1_q <= alu_out1_d;
      alu_out2_q <= alu_out2_d;
      rd_q <= rd_d;
      state_q <= state_d;
    end
  assign Flags = flags_q;
  assign CondEx = cond_ex_q;
  assign PCWrite = PCS && cond_ex_q;
  assign MemWrite = MemW && cond_ex_q;
  assign ALUOut1 = alu_out1_q;
  assign ALUOut2 = alu_out2_q;
  assign WBBusy = !idle;
  // A failed condition still walks the sequence so the controller sees WBDone; only the write enable is gated.
  assign RegWrite = !idle && RegW && cond_ex_q && !NoWrite;
  assign WBDone = state_q == WB_SINGLE || state_q == WB_HI;
  assign WA3 = idle ? '0 : (wb_lo ? lo_addr : rd_q);
  assign WD3 = idle ? '0 : (wb_lo ? alu_out2_q : alu_out1_q);
endmodule

// File: tb/tb_cond_wb_unit.sv
// tb_cond_wb_unit: directed stimulus against a queue-based behavioural model, checked every cycle, plus hand-computed literals
module tb_cond_wb_unit;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] Cond = '0, ALUFlags = '0;
  logic [1:0] FlagW = '0;
  logic CondLatch = 0, PCS = 0, RegW = 0, MemW = 0, NoWrite = 0, ResultLatch = 0, LongMul = 0, WBStart = 0;
  logic [31:0] Result1 = '0, Result2 = '0;
  logic [3:0] Rd = '0, RdLo = '0;
  logic [3:0] Flags, WA3;
  logic CondEx, PCWrite, MemWrite, RegWrite, WBBusy, WBDone;
  logic [31:0] WD3, ALUOut1, ALUOut2;
  int n_checks = 0, n_fail = 0;
`ifdef COND_WB_LONGMUL_EN
  localparam bit LM = 1'b1;
`else
  localparam bit LM = 1'b0;
`endif
  cond_wb_unit #(.DW(32), .AW(4)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .CondLatch(CondLatch),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Result1(Result1), .Result2(Result2),
    .ResultLatch(ResultLatch), .LongMul(LongMul), .WBStart(WBStart), .Rd(Rd), .RdLo(RdLo),
    .Flags(Flags), .CondEx(CondEx), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .WA3(WA3), .WD3(WD3), .ALUOut1(ALUOut1), .ALUOut2(ALUOut2), .WBBusy(WBBusy), .WBDone(WBDone)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0] addr; logic hi; logic done;} beat_t;
  logic [3:0] m_flags = '0;
  logic m_cex = 1'b0;
  logic [31:0] m_out1 = '0, m_out2 = '0;
  beat_t m_q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // ARM conditions come in complementary pairs: odd codes invert the even one; 111x is AL/NV.
  function automatic logic arm_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & !z;
      3'd5: base = n == v;
      3'd6: base = !z & (n == v);
      default: return !c[0];
    endcase
    return c[0] ? !base : base;
  endfunction
  task automatic model_step;
    logic p, busy;
    p = arm_pass(Cond, m_flags);
    if (FlagW[1] && m_cex) m_flags[3:2] = ALUFlags[3:2];
    if (FlagW[0] && m_cex) m_flags[1:0] = ALUFlags[1:0];
    if (CondLatch) m_cex = p;
    busy = m_q.size() != 0;
    if (ResultLatch && !busy) begin
      m_out1 = Result1;
      m_out2 = Result2;
    end
    if (busy) m_q.delete(0);
    if (!busy && WBStart) begin
      if (LM && LongMul) begin
        m_q.push_back(beat_t'{addr: RdLo, hi: 1'b0, done: 1'b0});
        m_q.push_back(beat_t'{addr: Rd, hi: 1'b1, done: 1'b1});
      end else m_q.push_back(beat_t'{addr: Rd, hi: 1'b1, done: 1'b1});
    end
  endtask
  task automatic model_reset;
    m_flags = '0;
    m_cex = 1'b0;
    m_out1 = '0;
    m_out2 = '0;
    m_q.delete();
  endtask
  task automatic tick;
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (reset === 1'b1) begin
      logic busy;
      busy = m_q.size() != 0;
      chk("Flags", 32'(Flags), 32'(m_flags));
      chk("CondEx", 32'(CondEx), 32'(m_cex));
      chk("PCWrite", 32'(PCWrite), 32'(PCS & m_cex));
      chk("MemWrite", 32'(MemWrite), 32'(MemW & m_cex));
      chk("ALUOut1", ALUOut1, m_out1);
      chk("ALUOut2", ALUOut2, m_out2);
      chk("WBBusy", 32'(WBBusy), 32'(busy));
      chk("RegWrite", 32'(RegWrite), 32'(busy & RegW & m_cex & !NoWrite));
      chk("WA3", 32'(WA3), busy ? 32'(m_q[0].addr) : 32'd0);
      chk("WD3", WD3, busy ? (m_q[0].hi ? m_out1 : m_out2) : 32'd0);
      chk("WBDone", 32'(WBDone), busy ? 32'(m_q[0].done) : 32'd0);
    end
  end
  task automatic set_flags(input logic [3:0] f);
    Cond = 4'b1110; CondLatch = 1; tick();
    CondLatch = 0; FlagW = 2'b11; ALUFlags = f; tick();
    FlagW = 2'b00;
  endtask
  // {flags, cond, expected pass}
  localparam logic [8:0] TV [8] = '{
    {4'b0001, 4'b1011, 1'b1}, {4'b1000, 4'b1010, 1'b0}, {4'b0010, 4'b1000, 1'b1}, {4'b0110, 4'b1000, 1'b0},
    {4'b0100, 4'b1101, 1'b1}, {4'b0000, 4'b1100, 1'b1}, {4'b1111, 4'b1111, 1'b0}, {4'b0000, 4'b1110, 1'b1}};
  initial begin
    #1;
    chk("reset Flags", 32'(Flags), 0);
    chk("reset CondEx", 32'(CondEx), 0);
    chk("reset WBBusy", 32'(WBBusy), 0);
    chk("reset RegWrite", 32'(RegWrite), 0);
    chk("reset WD3", WD3, 0);
    chk("reset ALUOut1", ALUOut1, 0);
    tick(); tick();
    reset = 1;
    set_flags(4'b0100);
    Cond = 4'b0000; CondLatch = 1; tick(); CondLatch = 0;
    chk("EQ CondEx", 32'(CondEx), 1);
    PCS = 1; MemW = 1; #1;
    chk("EQ PCWrite", 32'(PCWrite), 1);
    chk("EQ MemWrite", 32'(MemWrite), 1);
    Cond = 4'b0001; CondLatch = 1; tick(); CondLatch = 0;
    chk("NE CondEx", 32'(CondEx), 0);
    chk("NE PCWrite", 32'(PCWrite), 0);
    PCS = 0; MemW = 0;
    Cond = 4'b1110; CondLatch = 1; tick(); CondLatch = 0;
    FlagW = 2'b10; ALUFlags = 4'b1011; tick();
    chk("NZ update", 32'(Flags), 32'h8);
    FlagW = 2'b01; tick();
    chk("CV update", 32'(Flags), 32'hB);
    Cond = 4'b1111; CondLatch = 1; FlagW = 2'b11; ALUFlags = 4'b0000; tick(); CondLatch = 0;
    chk("old CondEx gates flags", 32'(Flags), 0);
    chk("NV CondEx", 32'(CondEx), 0);
    ALUFlags = 4'b1111; tick(); FlagW = 2'b00;
    chk("flags held when CondEx=0", 32'(Flags), 0);
    for (int i = 0; i < 8; i++) begin
      set_flags(TV[i][8:5]);
      Cond = TV[i][4:1]; CondLatch = 1; tick(); CondLatch = 0;
      chk("cond literal", 32'(CondEx), 32'(TV[i][0]));
    end
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c); CondLatch = 1; tick();
      end
      CondLatch = 0;
    end
    Cond = 4'b1110; CondLatch = 1; tick(); CondLatch = 0;
    Result1 = 32'h2A; Result2 = 32'h55; ResultLatch = 1; WBStart = 1; Rd = 4'd5; RegW = 1; tick();
    ResultLatch = 0; WBStart = 0; Rd = 4'd9; #1;
    chk("single RegWrite", 32'(RegWrite), 1);
    chk("single WA3", 32'(WA3), 5);
    chk("single WD3", WD3, 32'h2A);
    chk("single WBDone", 32'(WBDone), 1);
    chk("single ALUOut2", ALUOut2, 32'h55);
    tick();
    chk("single idle after", 32'(WBBusy), 0);
    Result1 = 32'h1; Result2 = 32'hFFFF_FFFE; ResultLatch = 1; tick(); ResultLatch = 0;
    LongMul = 1; Rd = 4'd3; RdLo = 4'd2; WBStart = 1; tick();
    Rd = 4'd7; Result1 = 32'hDEAD; ResultLatch = 1; #1;
    chk("lm beat1 WA3", 32'(WA3), LM ? 32'd2 : 32'd3);
    chk("lm beat1 WD3", WD3, LM ? 32'hFFFF_FFFE : 32'h1);
    chk("lm beat1 WBDone", 32'(WBDone), LM ? 32'd0 : 32'd1);
    tick();
    WBStart = 0; ResultLatch = 0;
    if (LM) begin
      chk("lm beat2 WA3", 32'(WA3), 3);
      chk("lm beat2 WD3", WD3, 32'h1);
      chk("lm beat2 WBDone", 32'(WBDone), 1);
    end
    tick();
    chk("lm idle after", 32'(WBBusy), 0);
    chk("lm ALUOut1 held", ALUOut1, 32'h1);
    Rd = 4'd4; RdLo = 4'd4; WBStart = 1; tick(); WBStart = 0;
    tick(); tick();
    LongMul = 0;
    Cond = 4'b1111; CondLatch = 1; tick(); CondLatch = 0;
    Rd = 4'd6; WBStart = 1; tick(); WBStart = 0; #1;
    chk("failed cond RegWrite", 32'(RegWrite), 0);
    chk("failed cond WBDone", 32'(WBDone), 1);
    tick();
    Cond = 4'b1110; CondLatch = 1; tick(); CondLatch = 0;
    NoWrite = 1; WBStart = 1; tick(); WBStart = 0; #1;
    chk("NoWrite RegWrite", 32'(RegWrite), 0);
    chk("NoWrite WBDone", 32'(WBDone), 1);
    tick(); NoWrite = 0;
    LongMul = 1; Rd = 4'd8; RdLo = 4'd9; WBStart = 1; tick(); WBStart = 0; #1;
    chk("pre-reset RegWrite", 32'(RegWrite), 1);
    #2 reset = 0; #1;
    chk("async WBBusy", 32'(WBBusy), 0);
    chk("async RegWrite", 32'(RegWrite), 0);
    chk("async WA3", 32'(WA3), 0);
    chk("async WD3", WD3, 0);
    chk("async Flags", 32'(Flags), 0);
    chk("async CondEx", 32'(CondEx), 0);
    chk("async ALUOut1", ALUOut1, 0);
    model_reset();
    tick();
    reset = 1; LongMul = 0;
    tick();
    chk("no WB_HI after reset", 32'(WBBusy), 0);
    Cond = 4'b1110; CondLatch = 1; tick(); CondLatch = 0;
    Result1 = 32'h77; ResultLatch = 1; WBStart = 1; Rd = 4'd1; tick();
    ResultLatch = 0; WBStart = 0; #1;
    chk("post-reset WA3", 32'(WA3), 1);
    chk("post-reset WD3", WD3, 32'h77);
    chk("post-reset RegWrite", 32'(RegWrite), 1);
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
